// File: rtl/cga_vram_arbiter_if.sv
// ---------------------------------------------------------------------------
// cga_vram_arbiter_if
//   Bus bundle between the CGA VRAM arbiter and its neighbours.
//   Display path : disp_slot, disp_addr                  (sequencer -> arbiter)
//   ISA CPU path : cpu_memr_l, cpu_memw_l, cpu_cs,
//                  cpu_addr, cpu_wdata                   (ISA -> arbiter)
//                  cpu_rdata, cpu_rdata_vld, bus_rdy     (arbiter -> ISA)
//   VRAM pins    : ram_a, ram_we_l, ram_dout             (arbiter -> VRAM)
//                  ram_din                               (VRAM -> arbiter)
//   Status       : timeout_err                           (arbiter -> system)
//   slave  modport = the arbiter itself
//   master modport = the surrounding system (sequencer, ISA glue, VRAM)
// ---------------------------------------------------------------------------
interface cga_vram_arbiter_if;
    logic        disp_slot;
    logic [18:0] disp_addr;
    logic        cpu_memr_l;
    logic        cpu_memw_l;
    logic        cpu_cs;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        cpu_rdata_vld;
    logic        bus_rdy;
    logic [18:0] ram_a;
    logic        ram_we_l;
    logic [7:0]  ram_dout;
    logic [7:0]  ram_din;
    logic        timeout_err;

    modport slave (
        input  disp_slot, disp_addr,
        input  cpu_memr_l, cpu_memw_l, cpu_cs, cpu_addr, cpu_wdata,
        output cpu_rdata, cpu_rdata_vld, bus_rdy,
        output ram_a, ram_we_l, ram_dout,
        input  ram_din,
        output timeout_err
    );

    modport master (
        output disp_slot, disp_addr,
        output cpu_memr_l, cpu_memw_l, cpu_cs, cpu_addr, cpu_wdata,
        input  cpu_rdata, cpu_rdata_vld, bus_rdy,
        input  ram_a, ram_we_l, ram_dout,
        output ram_din,
        input  timeout_err
    );
endinterface

// File: rtl/cga_vram_arbiter.sv
// ---------------------------------------------------------------------------
// cga_vram_arbiter
//   Shares the single-port CGA video RAM between display fetch and ISA CPU
//   memory cycles. Display always wins; a CPU access waits for a free slot,
//   performs one RAM cycle and holds the ISA bus in wait states (bus_rdy=0)
//   until the access completes.
// Ports
//   i_clk      system clock
//   i_reset_l  synchronous active-low reset
//   io_bus     cga_vram_arbiter_if.slave (display, ISA, VRAM, status signals)
// Parameters
//   USE_BUS_WAIT  1: hold bus_rdy low during an access; 0: bus_rdy tied high
//   VRAM_AW       CPU address bits forwarded to VRAM (14 = 16K mirror, 15 = 32K)
//   TIMEOUT       WAIT_SLOT cycles tolerated before the access is aborted
// ---------------------------------------------------------------------------
module cga_vram_arbiter #(
    parameter bit USE_BUS_WAIT = 1'b1,
    parameter int VRAM_AW      = 14,
    parameter int TIMEOUT      = 63
) (
    input  logic                 i_clk,
    input  logic                 i_reset_l,
    cga_vram_arbiter_if.slave    io_bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_ACCESS  = 3'd2;
    localparam logic [2:0] S_CAPTURE = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [5:0] TO_CNT = 6'(TIMEOUT);

    // Strobe synchronisers (ISA strobes are asynchronous to i_clk)
    logic               r_memr_s1, r_memr_s2;
    logic               r_memw_s1, r_memw_s2;

    logic [2:0]         r_state;
    logic [VRAM_AW-1:0] r_addr;
    logic [7:0]         r_wdata;
    logic               r_is_wr;
    logic [5:0]         r_wait_cnt;
    logic               r_bus_rdy;
    logic [7:0]         r_rdata;
    logic               r_rdata_vld;
    logic               r_timeout_err;

    logic               w_rd_req;
    logic               w_wr_req;
    logic               w_req;
    logic               w_strobe_held;
    logic               w_ram_we;
    logic               w_unused_addr;

    assign w_rd_req = io_bus.cpu_cs & ~r_memr_s2;
    assign w_wr_req = io_bus.cpu_cs & ~r_memw_s2;
    assign w_req    = w_rd_req | w_wr_req;

    // The access stays alive only while the strobe that started it is held.
    assign w_strobe_held = r_is_wr ? ~r_memw_s2 : ~r_memr_s2;

    // Write strobe is combinational so display can steal ACCESS the same cycle.
    assign w_ram_we = (r_state == S_ACCESS) & r_is_wr & ~io_bus.disp_slot;

    // Upper CPU address bits are intentionally dropped in the 16K mirror build.
    assign w_unused_addr = &{1'b0, io_bus.cpu_addr};

    always_ff @(posedge i_clk) begin
        if (!i_reset_l) begin
            r_memr_s1     <= 1'b1;
            r_memr_s2     <= 1'b1;
            r_memw_s1     <= 1'b1;
            r_memw_s2     <= 1'b1;
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_wdata       <= 8'h00;
            r_is_wr       <= 1'b0;
            r_wait_cnt    <= 6'd0;
            r_bus_rdy     <= 1'b1;
            r_rdata       <= 8'h00;
            r_rdata_vld   <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_memr_s1 <= io_bus.cpu_memr_l;
            r_memr_s2 <= r_memr_s1;
            r_memw_s1 <= io_bus.cpu_memw_l;
            r_memw_s2 <= r_memw_s1;

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr      <= io_bus.cpu_addr[VRAM_AW-1:0];
                        r_is_wr     <= w_wr_req;   // write wins if both strobes low
                        if (w_wr_req)
                            r_wdata <= io_bus.cpu_wdata;
                        r_bus_rdy   <= 1'b0;
                        r_rdata_vld <= 1'b0;
                        r_wait_cnt  <= 6'd0;
                        r_state     <= S_WAIT;
                    end
                end

                S_WAIT: begin
                    if (!w_strobe_held) begin
                        // CPU gave up: abandon without touching VRAM
                        r_bus_rdy <= 1'b1;
                        r_state   <= S_IDLE;
                    end else if (!io_bus.disp_slot) begin
                        r_state <= S_ACCESS;
                    end else if (r_wait_cnt == TO_CNT) begin
                        r_rdata       <= 8'hFF;
                        r_rdata_vld   <= ~r_is_wr;
                        r_timeout_err <= 1'b1;
                        r_bus_rdy     <= 1'b1;
                        r_state       <= S_DONE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 6'd1;
                    end
                end

                S_ACCESS: begin
                    if (io_bus.disp_slot) begin
                        // Display took the cycle; retry on the next free slot
                        r_wait_cnt <= 6'd0;
                        r_state    <= S_WAIT;
                    end else if (r_is_wr) begin
                        r_bus_rdy <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_state <= S_CAPTURE;
                    end
                end

                S_CAPTURE: begin
                    // RAM data for the ACCESS-cycle address arrives now
                    r_rdata     <= io_bus.ram_din;
                    r_rdata_vld <= 1'b1;
                    r_bus_rdy   <= 1'b1;
                    r_state     <= S_DONE;
                end

                S_DONE: begin
                    if (!w_strobe_held) begin
                        r_rdata_vld <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign io_bus.ram_a         = io_bus.disp_slot ? io_bus.disp_addr
                                                   : {{(19-VRAM_AW){1'b0}}, r_addr};
    assign io_bus.ram_we_l      = ~w_ram_we;
    assign io_bus.ram_dout      = r_wdata;
    assign io_bus.cpu_rdata     = r_rdata;
    assign io_bus.cpu_rdata_vld = r_rdata_vld;
    assign io_bus.bus_rdy       = USE_BUS_WAIT ? r_bus_rdy : 1'b1;
    assign io_bus.timeout_err   = r_timeout_err;

endmodule
